// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, reads instruction memory combinationally and
// registers the fetched word into IF/ID, with stall, redirect, halt and fault handling.
module if_stage #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] pc_o,
  output logic        ifid_valid_o,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc_plus4_o,
  output logic        halted_o,
  output logic        fault_o,
  output logic [31:0] fetch_count_o
);

  typedef enum logic [1:0] {BOOT, RUN, HALT, FAULT} state_e;

  localparam logic [31:0] PC_LIMIT = 32'(IMEM_DEPTH * 4);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        halted_q, halted_d;
  logic        fault_q, fault_d;
  logic [31:0] count_q, count_d;

  logic [31:0] pc_plus4;
  logic        redirect_aligned;
  logic        pc_in_range;
  logic        target_in_range;

  assign pc_plus4         = pc_q + 32'd4;
  assign redirect_aligned = (redirect_pc_i[1:0] == 2'b00);
  assign pc_in_range      = (pc_q < PC_LIMIT);
  assign target_in_range  = (redirect_pc_i < PC_LIMIT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      instr_q  <= 32'h0;
      pc4_q    <= 32'h0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
      count_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      pc4_q    <= pc4_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redirect_valid_i)  state_d = redirect_aligned ? RUN : FAULT;
        else if (stall_i)      state_d = RUN;
        else if (!pc_in_range) state_d = HALT;
      end
      HALT: begin
        if (redirect_valid_i) begin
          if (!redirect_aligned)    state_d = FAULT;
          else if (target_in_range) state_d = RUN;
        end
      end
      default: state_d = FAULT;
    endcase
  end

  // Datapath next-state; every non-fetching path flushes IF/ID so instr reads 0 when invalid.
  always_comb begin
    pc_d     = pc_q;
    valid_d  = 1'b0;
    instr_d  = 32'h0;
    pc4_d    = 32'h0;
    halted_d = halted_q;
    fault_d  = fault_q;
    count_d  = count_q;
    case (state_q)
      RUN: begin
        if (redirect_valid_i) begin
          if (redirect_aligned) pc_d = redirect_pc_i;
          else                  fault_d = 1'b1;
        end else if (stall_i) begin
          valid_d = valid_q;
          instr_d = instr_q;
          pc4_d   = pc4_q;
        end else if (!pc_in_range) begin
          halted_d = 1'b1;
        end else begin
          valid_d = 1'b1;
          instr_d = imem_data_i;
          pc4_d   = pc_plus4;
          pc_d    = pc_plus4;
          count_d = count_q + 32'd1;
        end
      end
      HALT: begin
        if (redirect_valid_i) begin
          if (!redirect_aligned) begin
            fault_d = 1'b1;
          end else if (target_in_range) begin
            pc_d     = redirect_pc_i;
            halted_d = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  assign imem_addr_o     = {pc_q[31:2], 2'b00};
  assign pc_o            = pc_q;
  assign ifid_valid_o    = valid_q;
  assign ifid_instr_o    = instr_q;
  assign ifid_pc_plus4_o = pc4_q;
  assign halted_o        = halted_q;
  assign fault_o         = fault_q;
  assign fetch_count_o   = count_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a 256-word instance and an 8-word instance share stimulus,
// each reading its own combinational model of instruction memory.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst, stall, rv;
  logic [31:0] rpc;
  logic [31:0] imem [256];

  logic [31:0] addr_a, data_a, pc_a, instr_a, pc4_a, cnt_a;
  logic        valid_a, halted_a, fault_a;
  logic [31:0] addr_b, data_b, pc_b, instr_b, pc4_b, cnt_b;
  logic        valid_b, halted_b, fault_b;

  int errors = 0;
  int checks = 0;
  int step_no = 0;

  always #5 clk = ~clk;

  assign data_a = imem[addr_a[9:2]];
  assign data_b = imem[addr_b[9:2]];

  if_stage #(.IMEM_DEPTH(256), .RESET_PC(32'h0)) u_big (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .redirect_valid_i(rv), .redirect_pc_i(rpc),
    .imem_addr_o(addr_a), .imem_data_i(data_a), .pc_o(pc_a), .ifid_valid_o(valid_a),
    .ifid_instr_o(instr_a), .ifid_pc_plus4_o(pc4_a), .halted_o(halted_a), .fault_o(fault_a),
    .fetch_count_o(cnt_a)
  );

  if_stage #(.IMEM_DEPTH(8), .RESET_PC(32'h0)) u_small (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .redirect_valid_i(rv), .redirect_pc_i(rpc),
    .imem_addr_o(addr_b), .imem_data_i(data_b), .pc_o(pc_b), .ifid_valid_o(valid_b),
    .ifid_instr_o(instr_b), .ifid_pc_plus4_o(pc4_b), .halted_o(halted_b), .fault_o(fault_b),
    .fetch_count_o(cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    step_no++;
    $display("step %0d: pc=%h valid=%b instr=%h pc4=%h halt=%b fault=%b cnt=%0d",
             step_no, pc_a, valid_a, instr_a, pc4_a, halted_a, fault_a, cnt_a);
  endtask

  task automatic check_a(input string tag, input logic [31:0] pc, input logic v,
                         input logic [31:0] ins, input logic [31:0] p4, input logic [31:0] cnt);
    check({tag, ".pc"}, pc_a, pc);
    check({tag, ".valid"}, {31'b0, valid_a}, {31'b0, v});
    check({tag, ".instr"}, instr_a, ins);
    check({tag, ".pc4"}, pc4_a, p4);
    check({tag, ".count"}, cnt_a, cnt);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 32'hA500_0000 | i;
    imem[0] = 32'h20010005;
    imem[1] = 32'h20020003;
    imem[2] = 32'h00221820;
    imem[3] = 32'h00000000;
    rst = 1'b1; stall = 1'b0; rv = 1'b0; rpc = 32'h0;

    // Reset state
    step();
    check_a("reset", 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    check("reset.halted", {31'b0, halted_a}, 32'h0);
    check("reset.fault", {31'b0, fault_a}, 32'h0);
    rst = 1'b0;

    // BOOT then sequential fetch
    step(); check_a("boot", 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    step(); check_a("fetch0", 32'h4, 1'b1, 32'h20010005, 32'h4, 32'h1);
    step(); check_a("fetch1", 32'h8, 1'b1, 32'h20020003, 32'h8, 32'h2);
    check("fetch1.addr", addr_a, 32'h8);

    // Two-cycle stall at PC=8
    stall = 1'b1;
    step(); check_a("stall1", 32'h8, 1'b1, 32'h20020003, 32'h8, 32'h2);
    step(); check_a("stall2", 32'h8, 1'b1, 32'h20020003, 32'h8, 32'h2);
    stall = 1'b0;
    step(); check_a("fetch2", 32'hC, 1'b1, 32'h00221820, 32'hC, 32'h3);

    // Redirect beats a simultaneous stall
    rv = 1'b1; rpc = 32'h40; stall = 1'b1;
    step(); check_a("redir", 32'h40, 1'b0, 32'h0, 32'h0, 32'h3);
    rv = 1'b0; stall = 1'b0;
    step(); check_a("target", 32'h44, 1'b1, 32'hA500_0010, 32'h44, 32'h4);

    // Misaligned redirect faults; later redirects ignored
    rv = 1'b1; rpc = 32'h42;
    step(); check_a("fault", 32'h44, 1'b0, 32'h0, 32'h0, 32'h4);
    check("fault.flag", {31'b0, fault_a}, 32'h1);
    rpc = 32'h0;
    step(); check_a("fault.hold", 32'h44, 1'b0, 32'h0, 32'h0, 32'h4);
    check("fault.sticky", {31'b0, fault_a}, 32'h1);
    check("fault.addr", addr_a, 32'h44);
    rv = 1'b0; rst = 1'b1;
    step(); check_a("fault.rst", 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    check("fault.rst.flag", {31'b0, fault_a}, 32'h0);
    rst = 1'b0;

    // Mid-run reset at PC=0x10
    step();
    for (int i = 1; i <= 4; i++) step();
    check_a("run16", 32'h10, 1'b1, 32'h0, 32'h10, 32'h4);
    rst = 1'b1;
    step(); check_a("midrst", 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    rst = 1'b0;
    step(); check_a("midrst.boot", 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    step(); check_a("midrst.fetch", 32'h4, 1'b1, 32'h20010005, 32'h4, 32'h1);

    // Small memory: run off the end, halt, then resume via redirect
    rst = 1'b1; step(); rst = 1'b0;
    step();
    for (int i = 1; i <= 8; i++) step();
    check("small.pc20", pc_b, 32'h20);
    check("small.last", instr_b, 32'hA500_0007);
    check("small.nohalt", {31'b0, halted_b}, 32'h0);
    step();
    check("small.halted", {31'b0, halted_b}, 32'h1);
    check("small.hvalid", {31'b0, valid_b}, 32'h0);
    check("small.hpc", pc_b, 32'h20);
    check("small.hcount", cnt_b, 32'h8);
    check("big.nohalt", {31'b0, halted_a}, 32'h0);
    check("big.pc", pc_a, 32'h24);
    stall = 1'b1;
    step();
    check("small.hold", pc_b, 32'h20);
    check("small.still", {31'b0, halted_b}, 32'h1);
    stall = 1'b0; rv = 1'b1; rpc = 32'h0;
    step();
    check("small.resume.pc", pc_b, 32'h0);
    check("small.resume.halt", {31'b0, halted_b}, 32'h0);
    check("small.resume.valid", {31'b0, valid_b}, 32'h0);
    rv = 1'b0;
    step();
    check("small.refetch.instr", instr_b, 32'h20010005);
    check("small.refetch.valid", {31'b0, valid_b}, 32'h1);
    check("small.refetch.pc", pc_b, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
